// File: rtl/sar_adc_pkg.sv
// ============================================================================
// Module      : sar_adc_pkg
// Description : Shared state encoding and oversampling constants for the SAR
//               ADC controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Oversampling: four passes averaged by a right shift of two.
    localparam int OS_PASSES = 4;
    localparam int OS_SHIFT  = 2;

endpackage

`default_nettype wire

// File: rtl/sar_adc_ctrl_if.sv
// ============================================================================
// Module      : sar_adc_ctrl_if
// Description : Request/result handshake between the data path (master) and
//               the SAR ADC controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sar_adc_ctrl_if #(
    parameter int BITS = 8,
    parameter int CH_W = 2
);
    logic            start;
    logic [CH_W-1:0] ch_sel;
    logic            busy;
    logic [BITS-1:0] data_out;
    logic [CH_W-1:0] data_ch;
    logic            valid;

    modport master (
        output start, ch_sel,
        input  busy, data_out, data_ch, valid
    );

    modport slave (
        input  start, ch_sel,
        output busy, data_out, data_ch, valid
    );
endinterface

`default_nettype wire

// File: rtl/sar_bit_seq.sv
// ============================================================================
// Module      : sar_bit_seq
// Description : Successive-approximation bit sequencer: result register, bit
//               index, settle counter and the trial/keep decision.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_bit_seq #(
    parameter int BITS          = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            clear,
    input  wire logic            load,
    input  wire logic            step,
    input  wire logic            comp,
    output logic [BITS-1:0]      dac_code,
    output logic [BITS-1:0]      result,
    output logic                 done
);

    localparam int IW = $clog2(BITS);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IW-1:0]   c_idx_top     = IW'(BITS - 1);
    localparam logic [CW-1:0]   c_settle_last = CW'(SETTLE_CYCLES - 1);
    localparam logic [BITS-1:0] c_msb         = {1'b1, {(BITS-1){1'b0}}};

    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;
    logic [BITS-1:0] r_result;
    logic [BITS-1:0] r_dac;

    logic [BITS-1:0] w_onehot;
    logic [BITS-1:0] w_kept;
    logic            w_last_settle;

    assign w_onehot      = BITS'(1) << r_idx;
    assign w_kept        = comp ? (r_result | w_onehot) : r_result;
    assign w_last_settle = (r_cnt == c_settle_last);

    assign done     = step && w_last_settle && (r_idx == '0);
    assign dac_code = r_dac;
    assign result   = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_dac    <= '0;
        end else if (clear) begin
            r_idx    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (load) begin
            r_idx    <= c_idx_top;
            r_cnt    <= '0;
            r_result <= '0;
            r_dac    <= c_msb;
        end else if (step) begin
            if (w_last_settle) begin
                r_cnt    <= '0;
                r_result <= w_kept;
                if (r_idx == '0) begin
                    r_dac <= '0;
                end else begin
                    // Next trial: decided bits plus the next lower bit.
                    r_idx <= r_idx - 1'b1;
                    r_dac <= w_kept | (w_onehot >> 1);
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
// ============================================================================
// Module      : sar_adc_ctrl
// Description : Parametrised SAR ADC controller: channel mux, track/hold,
//               DAC trial sequencing and start/busy/valid handshake.
//               Optional macro SAR_OVERSAMPLE_EN: four passes averaged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int BITS          = 8,
    parameter int CHANNELS      = 4,
    parameter int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sar_adc_ctrl_if.slave     bus,
    output logic [CH_W-1:0]   mux_sel,
    output logic              sample,
    output logic [BITS-1:0]   dac_code,
    input  wire logic         comp_in
);

    localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [SW-1:0] c_samp_last = SW'(SAMPLE_CYCLES - 1);

    state_t          r_state;
    logic            r_busy;
    logic            r_sample;
    logic [CH_W-1:0] r_mux_sel;
    logic [BITS-1:0] r_data_out;
    logic [CH_W-1:0] r_data_ch;
    logic            r_valid;
    logic [SW-1:0]   r_samp_cnt;

    logic            w_ch_ok;
    logic            w_accept;
    logic            w_seq_load;
    logic            w_seq_step;
    logic            w_seq_done;
    logic [BITS-1:0] w_seq_result;

    assign w_ch_ok    = (32'(bus.ch_sel) < 32'(CHANNELS));
    assign w_accept   = (r_state == IDLE) && bus.start && w_ch_ok;
    assign w_seq_load = (r_state == SAMPLE) && (r_samp_cnt == c_samp_last);
    assign w_seq_step = (r_state == CONVERT);

`ifdef SAR_OVERSAMPLE_EN
    localparam int AW = BITS + OS_SHIFT;
    localparam logic [1:0] c_pass_last = 2'(OS_PASSES - 1);

    logic [AW-1:0] r_acc;
    logic [1:0]    r_pass;
    logic [AW-1:0] w_sum;

    // Each pass's result is still held while the next pass samples, so it
    // is folded in at the start of the following CONVERT (pass 0 adds 0).
    assign w_sum = r_acc + {{OS_SHIFT{1'b0}}, w_seq_result};
`endif

    sar_bit_seq #(
        .BITS          (BITS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_bit_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_accept),
        .load     (w_seq_load),
        .step     (w_seq_step),
        .comp     (comp_in),
        .dac_code (dac_code),
        .result   (w_seq_result),
        .done     (w_seq_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_sample   <= 1'b0;
            r_mux_sel  <= '0;
            r_data_out <= '0;
            r_data_ch  <= '0;
            r_valid    <= 1'b0;
            r_samp_cnt <= '0;
`ifdef SAR_OVERSAMPLE_EN
            r_acc      <= '0;
            r_pass     <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mux_sel  <= bus.ch_sel;
                        r_busy     <= 1'b1;
                        r_sample   <= 1'b1;
                        r_samp_cnt <= '0;
`ifdef SAR_OVERSAMPLE_EN
                        r_acc      <= '0;
                        r_pass     <= '0;
`endif
                        r_state    <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (w_seq_load) begin
                        r_sample <= 1'b0;
`ifdef SAR_OVERSAMPLE_EN
                        r_acc    <= w_sum;
`endif
                        r_state  <= CONVERT;
                    end else begin
                        r_samp_cnt <= r_samp_cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    if (w_seq_done) begin
`ifdef SAR_OVERSAMPLE_EN
                        if (r_pass == c_pass_last) begin
                            r_state <= DONE;
                        end else begin
                            r_pass     <= r_pass + 1'b1;
                            r_sample   <= 1'b1;
                            r_samp_cnt <= '0;
                            r_state    <= SAMPLE;
                        end
`else
                        r_state <= DONE;
`endif
                    end
                end
                DONE: begin
`ifdef SAR_OVERSAMPLE_EN
                    r_data_out <= w_sum[AW-1:OS_SHIFT];
`else
                    r_data_out <= w_seq_result;
`endif
                    r_data_ch  <= r_mux_sel;
                    r_valid    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.data_out = r_data_out;
    assign bus.data_ch  = r_data_ch;
    assign bus.valid    = r_valid;
    assign mux_sel      = r_mux_sel;
    assign sample       = r_sample;

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
// ============================================================================
// Module      : tb_sar_adc_ctrl
// Description : Self-checking bench for sar_adc_ctrl with an ideal comparator
//               model and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_adc_ctrl;

`ifdef SAR_OVERSAMPLE_EN
    localparam int OS = 4;
`else
    localparam int OS = 1;
`endif
    localparam int LAT = 1 + OS * (2 + 8 * 2);

    typedef struct {
        logic [7:0] data;
        logic [2:0] ch;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] mux_sel;
    logic       sample;
    logic [7:0] dac_code;
    logic       comp_in;

    int         total = 0;
    int         bad = 0;
    exp_t       sb[$];
    logic [7:0] trials[$];
    int         sample_hi, busy_err, mux_err;
    int         comp_mode = 0;
    int         pass_idx = 0;
    logic [7:0] vin_tab [4];

    // Five channels so that out-of-range selects (5..7) fit in ch_sel.
    sar_adc_ctrl_if #(.BITS(8), .CH_W(3)) bus ();

    sar_adc_ctrl #(
        .BITS(8), .CHANNELS(5), .CH_W(3), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .mux_sel(mux_sel),
        .sample(sample), .dac_code(dac_code), .comp_in(comp_in)
    );

    always #5 clk = ~clk;

    // Ideal comparator: Vin sits half an LSB above its code.
    always_comb begin
        comp_in = 1'b0;
        case (comp_mode)
            0:       comp_in = ({vin_tab[pass_idx], 1'b1} > {dac_code, 1'b0});
            1:       comp_in = 1'b1;
            default: comp_in = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.valid) begin
            check("valid_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("data_out", 32'(bus.data_out), 32'(e.data));
                check("data_ch", 32'(bus.data_ch), 32'(e.ch));
            end
        end
    end

    task automatic set_vin(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        vin_tab[0] = a; vin_tab[1] = b; vin_tab[2] = c; vin_tab[3] = d;
    endtask

    task automatic run_conv(input int ch, input logic [7:0] exp_data, input bit inject,
                            input int abort_at, output int lat);
        logic       prev_s;
        logic [7:0] prev_dac;
        int         rises;
        trials.delete();
        sample_hi = 0; busy_err = 0; mux_err = 0; lat = -1;
        prev_s = 1'b0; prev_dac = 8'h00; rises = 0; pass_idx = 0;
        bus.start  = 1'b1;
        bus.ch_sel = 3'(ch);
        if (abort_at < 0) sb.push_back('{exp_data, 3'(ch)});
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (n == 0) bus.start = 1'b0;
            if (inject && (n == 5 || n == 10)) begin bus.start = 1'b1; bus.ch_sel = 3'd3; end
            if (inject && (n == 6 || n == 11)) begin bus.start = 1'b0; bus.ch_sel = 3'(ch); end
            if (sample && !prev_s) begin
                pass_idx = (rises > 3) ? 3 : rises;
                rises++;
            end
            prev_s = sample;
            if (sample) sample_hi++;
            if (dac_code != 8'h00 && dac_code != prev_dac) trials.push_back(dac_code);
            prev_dac = dac_code;
            if (mux_sel !== 3'(ch)) mux_err++;
            if (n == abort_at) begin
                rst_n = 1'b0;
                sb.delete();
                return;
            end
            if (bus.valid) begin
                lat = n;
                if (bus.busy !== 1'b0) busy_err++;
                break;
            end else if (bus.busy !== 1'b1) begin
                busy_err++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_valid"}, 32'(bus.valid), 0);
        check({tag, "_data_out"}, 32'(bus.data_out), 0);
        check({tag, "_data_ch"}, 32'(bus.data_ch), 0);
        check({tag, "_sample"}, 32'(sample), 0);
        check({tag, "_dac_code"}, 32'(dac_code), 0);
        check({tag, "_mux_sel"}, 32'(mux_sel), 0);
    endtask

    initial begin
        int         lat;
        logic [7:0] held;
        logic [7:0] exp_trials [8];
        exp_trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        bus.start = 1'b0; bus.ch_sel = 3'd0;
        set_vin(8'h00, 8'h00, 8'h00, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ideal comparator, code 0xA5 on channel 2
        set_vin(8'hA5, 8'hA5, 8'hA5, 8'hA5);
        run_conv(2, 8'hA5, 1'b0, -1, lat);
        check("a5_latency", lat, LAT);
        for (int i = 0; i < 8; i++)
            check($sformatf("a5_trial%0d", i),
                  (trials.size() > i) ? 32'(trials[i]) : 32'hFFFF_FFFF, 32'(exp_trials[i]));
        check("a5_sample_cycles", sample_hi, 2 * OS);
        check("a5_busy", busy_err, 0);
        check("a5_mux_stable", mux_err, 0);

        // Comparator stuck high / low
        comp_mode = 1;
        run_conv(0, 8'hFF, 1'b0, -1, lat);
        check("ones_latency", lat, LAT);
        check("ones_sample_cycles", sample_hi, 2 * OS);
        comp_mode = 2;
        run_conv(3, 8'h00, 1'b0, -1, lat);
        check("zeros_latency", lat, LAT);
        check("zeros_sample_cycles", sample_hi, 2 * OS);
        comp_mode = 0;
        @(posedge clk); #1;

        // Starts during a conversion are ignored; back-to-back accept after valid
        set_vin(8'h3C, 8'h3C, 8'h3C, 8'h3C);
        run_conv(1, 8'h3C, 1'b1, -1, lat);
        check("ignore_latency", lat, LAT);
        check("ignore_mux_stable", mux_err, 0);
        check("ignore_busy", busy_err, 0);
        set_vin(8'h5A, 8'h5A, 8'h5A, 8'h5A);
        run_conv(4, 8'h5A, 1'b0, -1, lat);
        check("b2b_latency", lat, LAT);
        @(posedge clk); #1;

        // Out-of-range channel requests
        held = bus.data_out;
        busy_err = 0;
        for (int c = 5; c < 8; c++) begin
            bus.start = 1'b1; bus.ch_sel = 3'(c);
            repeat (3) begin
                @(posedge clk); #1;
                if (bus.busy !== 1'b0) busy_err++;
            end
        end
        bus.start = 1'b0; bus.ch_sel = 3'd0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.valid !== 1'b0) busy_err++;
        end
        check("badch_no_busy", busy_err, 0);
        check("badch_data_held", 32'(bus.data_out), 32'(held));

        // Reset in the middle of a conversion
        set_vin(8'h77, 8'h77, 8'h77, 8'h77);
        run_conv(3, 8'h77, 1'b0, 10, lat);
        #1;
        check_all_zero("abort");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        set_vin(8'h96, 8'h96, 8'h96, 8'h96);
        run_conv(2, 8'h96, 1'b0, -1, lat);
        check("post_reset_latency", lat, LAT);
        @(posedge clk); #1;

        // Pass-varying input: averaged when oversampling, first pass otherwise
        set_vin(8'h10, 8'h11, 8'h11, 8'h12);
`ifdef SAR_OVERSAMPLE_EN
        run_conv(1, 8'h11, 1'b0, -1, lat);
`else
        run_conv(1, 8'h10, 1'b0, -1, lat);
`endif
        check("os_latency", lat, LAT);
        check("os_sample_cycles", sample_hi, 2 * OS);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
